upsampler_multi: RTL



---
 rtl/upsampler_multi.sv | 109 ++++++++++
 1 files changed

// File: rtl/upsampler_multi.sv
// upsampler_multi
//   Symbol upsampler for the transmit sample path. Each accepted symbol is
//   expanded into L = max(factor,1) samples, one per clock, either
//   zero-stuffed (mode=0) or sample-held (mode=1). A new symbol may be
//   accepted on the last sample of the current one for a gapless stream.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   new_symbol    input_data valid this cycle (single-cycle request)
//   input_data    symbol value (DATA_W)
//   factor        upsampling factor L (FACTOR_W), 0 behaves as 1
//   mode          0 = zero-stuff, 1 = sample-hold
//   clear_ovr     synchronous clear of overrun
//   output_data   registered output sample
//   out_valid     output_data carries a sample of a symbol
//   sym_start     first sample of a symbol
//   busy          symbol in progress and not on its last sample
//   overrun       sticky: a symbol was dropped
module upsampler_multi #(
  parameter int DATA_W   = 4,
  parameter int FACTOR_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                new_symbol,
  input  logic [DATA_W-1:0]   input_data,
  input  logic [FACTOR_W-1:0] factor,
  input  logic                mode,
  input  logic                clear_ovr,
  output logic [DATA_W-1:0]   output_data,
  output logic                out_valid,
  output logic                sym_start,
  output logic                busy,
  output logic                overrun
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [FACTOR_W-1:0] cnt, cnt_nxt, leff_m1;
  logic [DATA_W-1:0]   hold_val, hold_nxt, data_nxt;
  logic                mode_lat, mode_nxt;
  logic                vld_nxt, start_nxt, ovr_nxt;
  logic                last, accept, reject;

  // cnt counts samples remaining after the current one, so cnt == 0 marks
  // the last sample (and is also the resting value in IDLE).
  assign last    = (cnt == '0);
  assign accept  = new_symbol && (state == IDLE || last);
  assign reject  = new_symbol && (state == ACTIVE) && !last;
  assign leff_m1 = (factor == '0) ? '0 : factor - FACTOR_W'(1);
  assign busy    = (state == ACTIVE) && !last;

  // State register (plus datapath registers)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      hold_val    <= '0;
      mode_lat    <= 1'b0;
      output_data <= '0;
      out_valid   <= 1'b0;
      sym_start   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      hold_val    <= hold_nxt;
      mode_lat    <= mode_nxt;
      output_data <= data_nxt;
      out_valid   <= vld_nxt;
      sym_start   <= start_nxt;
      overrun     <= ovr_nxt;
    end
  end

  // Next-state
  always_comb begin
    state_nxt = state;
    if (accept)                      state_nxt = ACTIVE;
    else if (state == ACTIVE && last) state_nxt = IDLE;
  end

  // Next outputs / datapath
  always_comb begin
    cnt_nxt   = cnt;
    hold_nxt  = hold_val;
    mode_nxt  = mode_lat;
    data_nxt  = '0;
    vld_nxt   = 1'b0;
    start_nxt = 1'b0;
    if (accept) begin
      // factor and mode are sampled only here; mid-symbol changes wait
      cnt_nxt   = leff_m1;
      hold_nxt  = input_data;
      mode_nxt  = mode;
      data_nxt  = input_data;
      vld_nxt   = 1'b1;
      start_nxt = 1'b1;
    end else if (state == ACTIVE && !last) begin
      cnt_nxt  = cnt - FACTOR_W'(1);
      data_nxt = mode_lat ? hold_val : '0;
      vld_nxt  = 1'b1;
    end
    // set wins over clear
    ovr_nxt = reject | (overrun & ~clear_ovr);
  end

endmodule
